// File: rtl/sgde_pkg.sv
// Shared constants, FSM state type and sprite descriptor for the sprite engine.
package sgde_pkg;

  localparam int unsigned FB_DIM      = 64;
  localparam int unsigned SPR_DIM     = 16;
  localparam int unsigned MAX_SPRITES = 20;
  localparam int unsigned FB_WORDS    = FB_DIM * FB_DIM;
  localparam int unsigned SPR_PIXELS  = SPR_DIM * SPR_DIM;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    CLEAR,
    DRAW,
    DONE
  } state_t;

  typedef struct packed {
    logic [5:0] x;
    logic [5:0] y;
    logic [1:0] stype;
  } sprite_t;

  // Sprite ROM word address: {type[0], srow, scol}; type[1] selects the ROM.
  function automatic logic [8:0] sr_addr(input logic [1:0] stype, input logic [7:0] pix);
    return {stype[0], pix};
  endfunction

endpackage

// File: rtl/sgde_sprite_list.sv
// Sprite descriptor register file: append-only write side, sequential read side.
module sgde_sprite_list
  import sgde_pkg::*;
#(
  parameter int unsigned MAX_SPRITES = sgde_pkg::MAX_SPRITES,
  parameter int unsigned CW          = $clog2(MAX_SPRITES + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          wr_en,
  input  sprite_t       wr_desc,
  input  logic          rd_rst,
  input  logic          rd_next,
  output sprite_t       rd_desc,
  output logic          rd_last,
  output logic [CW-1:0] count
);

  sprite_t       mem_q [MAX_SPRITES];
  sprite_t       mem_d [MAX_SPRITES];
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] rd_idx_q, rd_idx_d;

  // Append on write while space remains; clear empties list and rewinds read index.
  always_comb begin
    mem_d    = mem_q;
    count_d  = count_q;
    rd_idx_d = rd_idx_q;
    if (clr) begin
      count_d  = '0;
      rd_idx_d = '0;
    end else begin
      if (wr_en && (32'(count_q) < MAX_SPRITES)) begin
        mem_d[count_q] = wr_desc;
        count_d        = count_q + 1'b1;
      end
      if (rd_rst) begin
        rd_idx_d = '0;
      end else if (rd_next) begin
        rd_idx_d = rd_idx_q + 1'b1;
      end
    end
  end

  // List storage, count and read index registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '{default: '0};
      count_q  <= '0;
      rd_idx_q <= '0;
    end else begin
      mem_q    <= mem_d;
      count_q  <= count_d;
      rd_idx_q <= rd_idx_d;
    end
  end

  // Read port and end-of-list flag.
  always_comb begin
    rd_desc = mem_q[rd_idx_q];
    rd_last = (rd_idx_q == count_q - 1'b1);
    count   = count_q;
  end

endmodule

// File: rtl/sgde_engine.sv
// Sprite engine: clears a 64x64 frame buffer to a background colour, then
// draws the loaded 16x16 sprites in load order with transparency and clipping.
module sgde_engine
  import sgde_pkg::*;
#(
  parameter int unsigned MAX_SPRITES = sgde_pkg::MAX_SPRITES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sprite,
  input  logic        start,
  input  logic [5:0]  X,
  input  logic [5:0]  Y,
  input  logic [1:0]  spr_type,   // sprite index ("type" is a reserved word)
  output logic        ready,
  output logic        done,
  output logic        SR0_CEN,
  output logic [8:0]  SR0_A,
  input  logic [12:0] SR0_Q,
  output logic        SR1_CEN,
  output logic [8:0]  SR1_A,
  input  logic [12:0] SR1_Q,
  output logic        FB_CEN,
  output logic        FB_WEN,
  output logic [11:0] FB_A,
  output logic [11:0] FB_D,
  input  logic [11:0] FB_Q,
  input  logic [11:0] bg_color,
  input  logic [1:0]  game_mode
);

  localparam int unsigned CW = $clog2(MAX_SPRITES + 1);

  state_t        state_q, state_d;
  logic          ready_q, ready_d;
  logic          done_q, done_d;
  logic          sr0_cen_q, sr0_cen_d, sr1_cen_q, sr1_cen_d;
  logic [8:0]    sr0_a_q, sr0_a_d, sr1_a_q, sr1_a_d;
  logic          fb_cen_q, fb_cen_d, fb_wen_q, fb_wen_d;
  logic [11:0]   fb_a_q, fb_a_d, fb_d_q, fb_d_d;
  logic [12:0]   clr_cnt_q, clr_cnt_d;
  logic [7:0]    pix_q, pix_d;
  logic          issue_q, issue_d;
  // s1: ROM address in flight; s2: ROM data available this cycle
  logic          s1_vld_q, s1_vld_d, s2_vld_q, s2_vld_d;
  logic [11:0]   s1_fba_q, s1_fba_d, s2_fba_q, s2_fba_d;
  logic          s1_inb_q, s1_inb_d, s2_inb_q, s2_inb_d;
  logic          s1_rom_q, s1_rom_d, s2_rom_q, s2_rom_d;

  logic          list_wr, list_clr, list_rd_rst, list_rd_next, list_last;
  sprite_t       new_desc, cur;
  logic [CW-1:0] list_count;
  logic [6:0]    col_sum, row_sum;
  logic [12:0]   rom_q;
  logic          fb_q_unused;

  sgde_sprite_list #(
    .MAX_SPRITES(MAX_SPRITES),
    .CW         (CW)
  ) u_list (
    .clk    (clk),
    .rst_n  (reset),
    .clr    (list_clr),
    .wr_en  (list_wr),
    .wr_desc(new_desc),
    .rd_rst (list_rd_rst),
    .rd_next(list_rd_next),
    .rd_desc(cur),
    .rd_last(list_last),
    .count  (list_count)
  );

  // Frame buffer read data is not consumed by the renderer.
  always_comb fb_q_unused = ^FB_Q;

  // Next-state, address generation and two-stage ROM-to-FB draw pipeline.
  always_comb begin
    state_d      = state_q;
    ready_d      = ready_q;
    done_d       = 1'b0;
    sr0_cen_d    = 1'b1;
    sr1_cen_d    = 1'b1;
    sr0_a_d      = sr0_a_q;
    sr1_a_d      = sr1_a_q;
    fb_cen_d     = 1'b1;
    fb_wen_d     = 1'b1;
    fb_a_d       = fb_a_q;
    fb_d_d       = fb_d_q;
    clr_cnt_d    = clr_cnt_q;
    pix_d        = pix_q;
    issue_d      = issue_q;
    s1_vld_d     = 1'b0;
    s1_fba_d     = s1_fba_q;
    s1_inb_d     = s1_inb_q;
    s1_rom_d     = s1_rom_q;
    s2_vld_d     = s1_vld_q;
    s2_fba_d     = s1_fba_q;
    s2_inb_d     = s1_inb_q;
    s2_rom_d     = s1_rom_q;
    list_wr      = 1'b0;
    list_clr     = 1'b0;
    list_rd_rst  = 1'b0;
    list_rd_next = 1'b0;
    new_desc     = {X, Y, spr_type};
    col_sum      = {1'b0, cur.x} + {3'b000, pix_q[3:0]};
    row_sum      = {1'b0, cur.y} + {3'b000, pix_q[7:4]};
    rom_q        = s2_rom_q ? SR1_Q : SR0_Q;

    case (state_q)
      IDLE, LOAD: begin
        ready_d = 1'b1;
        if (start) begin
          state_d     = CLEAR;
          ready_d     = 1'b0;
          clr_cnt_d   = '0;
          list_rd_rst = 1'b1;
        end else if (sprite) begin
          list_wr = 1'b1;
          state_d = LOAD;
        end
      end

      CLEAR: begin
        // Extra count (bit 12 set) lets the final clear write complete before leaving.
        if (!clr_cnt_q[12]) begin
          fb_cen_d  = 1'b0;
          fb_wen_d  = 1'b0;
          fb_a_d    = clr_cnt_q[11:0];
          fb_d_d    = bg_color;
          clr_cnt_d = clr_cnt_q + 13'd1;
        end else if (list_count == '0) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          state_d = DRAW;
          pix_d   = '0;
          issue_d = 1'b1;
        end
      end

      DRAW: begin
        if (issue_q) begin
          s1_vld_d = 1'b1;
          s1_fba_d = {row_sum[5:0], col_sum[5:0]};
          s1_inb_d = !col_sum[6] && !row_sum[6];
          s1_rom_d = cur.stype[1];
          if (cur.stype[1]) begin
            sr1_cen_d = 1'b0;
            sr1_a_d   = sr_addr(cur.stype, pix_q);
          end else begin
            sr0_cen_d = 1'b0;
            sr0_a_d   = sr_addr(cur.stype, pix_q);
          end
          pix_d = pix_q + 8'd1;
          if (pix_q == 8'hFF) begin
            if (list_last) begin
              issue_d = 1'b0;
            end else begin
              list_rd_next = 1'b1;
            end
          end
        end
        if (s2_vld_q && s2_inb_q && ((game_mode == 2'd1) || !rom_q[12])) begin
          fb_cen_d = 1'b0;
          fb_wen_d = 1'b0;
          fb_a_d   = s2_fba_q;
          fb_d_d   = rom_q[11:0];
        end
        // Pipeline empty: the last registered write is performed on this edge.
        if (!issue_q && !s1_vld_q && !s2_vld_q) begin
          state_d = DONE;
          done_d  = 1'b1;
        end
      end

      DONE: begin
        state_d  = IDLE;
        ready_d  = 1'b1;
        list_clr = 1'b1;
      end

      default: begin
        state_d = IDLE;
        ready_d = 1'b1;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      ready_q   <= 1'b1;
      done_q    <= 1'b0;
      sr0_cen_q <= 1'b1;
      sr1_cen_q <= 1'b1;
      sr0_a_q   <= '0;
      sr1_a_q   <= '0;
      fb_cen_q  <= 1'b1;
      fb_wen_q  <= 1'b1;
      fb_a_q    <= '0;
      fb_d_q    <= '0;
      clr_cnt_q <= '0;
      pix_q     <= '0;
      issue_q   <= 1'b0;
      s1_vld_q  <= 1'b0;
      s1_fba_q  <= '0;
      s1_inb_q  <= 1'b0;
      s1_rom_q  <= 1'b0;
      s2_vld_q  <= 1'b0;
      s2_fba_q  <= '0;
      s2_inb_q  <= 1'b0;
      s2_rom_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      ready_q   <= ready_d;
      done_q    <= done_d;
      sr0_cen_q <= sr0_cen_d;
      sr1_cen_q <= sr1_cen_d;
      sr0_a_q   <= sr0_a_d;
      sr1_a_q   <= sr1_a_d;
      fb_cen_q  <= fb_cen_d;
      fb_wen_q  <= fb_wen_d;
      fb_a_q    <= fb_a_d;
      fb_d_q    <= fb_d_d;
      clr_cnt_q <= clr_cnt_d;
      pix_q     <= pix_d;
      issue_q   <= issue_d;
      s1_vld_q  <= s1_vld_d;
      s1_fba_q  <= s1_fba_d;
      s1_inb_q  <= s1_inb_d;
      s1_rom_q  <= s1_rom_d;
      s2_vld_q  <= s2_vld_d;
      s2_fba_q  <= s2_fba_d;
      s2_inb_q  <= s2_inb_d;
      s2_rom_q  <= s2_rom_d;
    end
  end

  assign ready   = ready_q;
  assign done    = done_q;
  assign SR0_CEN = sr0_cen_q;
  assign SR0_A   = sr0_a_q;
  assign SR1_CEN = sr1_cen_q;
  assign SR1_A   = sr1_a_q;
  assign FB_CEN  = fb_cen_q;
  assign FB_WEN  = fb_wen_q;
  assign FB_A    = fb_a_q;
  assign FB_D    = fb_d_q;

endmodule

// File: tb/tb_sgde_engine.sv
// Self-checking bench for sgde_engine: memory models, frame reference model,
// table-driven frames, hand sequences and randomized frames.
module tb_sgde_engine;

  localparam int MAXS = 20;

  logic        clk, rst_n, sprite, start;
  logic [5:0]  X, Y;
  logic [1:0]  spr_type;
  logic        ready, done;
  logic        SR0_CEN, SR1_CEN, FB_CEN, FB_WEN;
  logic [8:0]  SR0_A, SR1_A;
  logic [12:0] SR0_Q, SR1_Q;
  logic [11:0] FB_A, FB_D, FB_Q, bg_color;
  logic [1:0]  game_mode;

  sgde_engine #(.MAX_SPRITES(MAXS)) dut (
    .clk(clk), .reset(rst_n), .sprite(sprite), .start(start),
    .X(X), .Y(Y), .spr_type(spr_type), .ready(ready), .done(done),
    .SR0_CEN(SR0_CEN), .SR0_A(SR0_A), .SR0_Q(SR0_Q),
    .SR1_CEN(SR1_CEN), .SR1_A(SR1_A), .SR1_Q(SR1_Q),
    .FB_CEN(FB_CEN), .FB_WEN(FB_WEN), .FB_A(FB_A), .FB_D(FB_D), .FB_Q(FB_Q),
    .bg_color(bg_color), .game_mode(game_mode)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [12:0] rom0 [512];
  logic [12:0] rom1 [512];
  logic [11:0] fb_mem [4096];
  logic [11:0] fb_exp [4096];
  logic [5:0]  sx [32];
  logic [5:0]  sy [32];
  logic [1:0]  st [32];

  int unsigned wr_total, viol_total, sr0_total, sr1_lo_total, sr1_hi_total;
  int n_checks = 0;
  int n_fail   = 0;

  // Synchronous single-port memories and access monitors.
  always @(posedge clk) begin
    if (!SR0_CEN) SR0_Q <= rom0[SR0_A];
    if (!SR1_CEN) SR1_Q <= rom1[SR1_A];
    if (!FB_CEN) begin
      if (!FB_WEN) fb_mem[FB_A] <= FB_D;
      else         FB_Q <= fb_mem[FB_A];
    end
    if (rst_n) begin
      if (!FB_CEN && !FB_WEN) wr_total <= wr_total + 1;
      if (!SR0_CEN) sr0_total <= sr0_total + 1;
      if (!SR1_CEN && !SR1_A[8]) sr1_lo_total <= sr1_lo_total + 1;
      if (!SR1_CEN &&  SR1_A[8]) sr1_hi_total <= sr1_hi_total + 1;
      viol_total <= viol_total + ((!SR0_CEN && !SR1_CEN) ? 1 : 0)
                  + ((ready && (!FB_CEN || !SR0_CEN || !SR1_CEN)) ? 1 : 0);
    end
  end

  initial begin
    wr_total = 0; viol_total = 0; sr0_total = 0; sr1_lo_total = 0; sr1_hi_total = 0;
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference frame: background, then each accepted sprite painted in order.
  task automatic build_expected(input int n, input logic [1:0] mode, input logic [11:0] bg,
                                output int exp_writes, output int e_sr0, output int e_lo,
                                output int e_hi);
    int drawn;
    logic [12:0] w;
    logic [8:0]  ra;
    drawn = (n > MAXS) ? MAXS : n;
    exp_writes = 4096; e_sr0 = 0; e_lo = 0; e_hi = 0;
    for (int a = 0; a < 4096; a++) fb_exp[a] = bg;
    for (int i = 0; i < drawn; i++) begin
      if (st[i] < 2) e_sr0 += 256; else if (st[i] == 2) e_lo += 256; else e_hi += 256;
      for (int r = 0; r < 16; r++) begin
        for (int c = 0; c < 16; c++) begin
          if (int'(sx[i]) + c < 64 && int'(sy[i]) + r < 64) begin
            ra = {st[i][0], 4'(r), 4'(c)};
            w  = st[i][1] ? rom1[ra] : rom0[ra];
            if (mode == 2'd1 || !w[12]) begin
              fb_exp[(int'(sy[i]) + r) * 64 + int'(sx[i]) + c] = w[11:0];
              exp_writes++;
            end
          end
        end
      end
    end
  endtask

  task automatic load_and_start(input int n, input bit coincide);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      sprite = 1'b1; X = sx[i]; Y = sy[i]; spr_type = st[i];
    end
    @(negedge clk);
    check("ready_before_start", ready, 1);
    start = 1'b1;
    sprite = coincide;
    X = 6'd20; Y = 6'd20; spr_type = 2'd0;
    @(negedge clk);
    start = 1'b0; sprite = 1'b0;
    check("ready_busy", ready, 0);
  endtask

  task automatic run_frame(input int n, input logic [1:0] mode, input logic [11:0] bg,
                           input bit coincide, input bit junk);
    int unsigned w0, v0, s0, l0, h0;
    int lat, bound, drawn, exp_w, e_sr0, e_lo, e_hi, mism, bad_a;
    game_mode = mode; bg_color = bg;
    drawn = (n > MAXS) ? MAXS : n;
    bound = 4096 + drawn * 258 + 4;
    w0 = wr_total; v0 = viol_total; s0 = sr0_total; l0 = sr1_lo_total; h0 = sr1_hi_total;
    load_and_start(n, coincide);
    lat = 0;
    while (!done && lat < bound + 50) begin
      @(negedge clk);
      lat++;
      if (junk) begin
        sprite = lat[1]; X = 6'($urandom); Y = 6'($urandom); spr_type = 2'($urandom);
      end
    end
    sprite = 1'b0;
    check("done_within_bound", (done === 1'b1 && lat <= bound) ? 1 : 0, 1);
    check("fb_idle_in_done", {31'd0, FB_CEN}, 1);
    @(negedge clk);
    check("done_one_cycle", done, 0);
    check("ready_after_done", ready, 1);
    build_expected(n, mode, bg, exp_w, e_sr0, e_lo, e_hi);
    mism = 0; bad_a = 0;
    for (int a = 0; a < 4096; a++) begin
      if (fb_mem[a] !== fb_exp[a]) begin
        if (mism == 0) bad_a = a;
        mism++;
      end
    end
    n_checks++;
    if (mism != 0) begin
      n_fail++;
      $display("FAIL frame_contents: %0d words differ, first at 0x%0h got 0x%0h expected 0x%0h",
               mism, bad_a, fb_mem[bad_a], fb_exp[bad_a]);
    end
    check("fb_write_count", int'(wr_total - w0), exp_w);
    check("sr0_reads", int'(sr0_total - s0), e_sr0);
    check("sr1_lo_reads", int'(sr1_lo_total - l0), e_lo);
    check("sr1_hi_reads", int'(sr1_hi_total - h0), e_hi);
    check("protocol", int'(viol_total - v0), 0);
  endtask

  typedef struct packed {
    logic [5:0]  n;
    logic [1:0]  mode;
    logic [11:0] bg;
    logic [5:0]  x0, y0;
    logic [1:0]  t0;
    logic [5:0]  x1, y1;
    logic [1:0]  t1;
    logic [11:0] pa0, pe0, pa1, pe1;
  } vec_t;

  vec_t vt [6];
  int   found;

  initial begin
    rst_n = 1'b0; sprite = 1'b0; start = 1'b0; X = '0; Y = '0; spr_type = '0;
    bg_color = '0; game_mode = '0;

    // Deterministic ROMs: colour = {type, 2'b01, srow, scol};
    // ROM0 transparent on srow==scol, ROM1 on srow==15-scol.
    for (int a = 0; a < 512; a++) begin
      logic [8:0] av;
      av = 9'(a);
      rom0[a] = {(av[7:4] == av[3:0]),  1'b0, av[8], 2'b01, av[7:0]};
      rom1[a] = {(av[7:4] == ~av[3:0]), 1'b1, av[8], 2'b01, av[7:0]};
    end

    //          n   mode  bg        x0 y0 t0  x1 y1 t1  pa0      pe0      pa1      pe1
    vt[0] = {6'd0,  2'd0, 12'hB97, 6'd0, 6'd0, 2'd0, 6'd0, 6'd0, 2'd0, 12'h000, 12'hB97, 12'hFFF, 12'hB97};
    vt[1] = {6'd1,  2'd0, 12'hA5A, 6'd0, 6'd0, 2'd0, 6'd0, 6'd0, 2'd0, 12'h083, 12'h123, 12'h145, 12'hA5A};
    vt[2] = {6'd1,  2'd0, 12'h3C3, 6'd60, 6'd60, 2'd3, 6'd0, 6'd0, 2'd0, 12'hF3D, 12'hD01, 12'hF00, 12'h3C3};
    vt[3] = {6'd2,  2'd0, 12'h0F0, 6'd10, 6'd10, 2'd1, 6'd10, 6'd10, 2'd2, 12'h2CC, 12'h912, 12'h299, 12'h50F};
    vt[4] = {6'd21, 2'd0, 12'h777, 6'd0, 6'd0, 2'd0, 6'd40, 6'd40, 2'd2, 12'hA29, 12'h777, 12'h083, 12'h123};
    vt[5] = {6'd1,  2'd1, 12'h246, 6'd0, 6'd0, 2'd0, 6'd0, 6'd0, 2'd0, 12'h145, 12'h155, 12'h000, 12'h100};

    repeat (3) @(negedge clk);
    check("rst_ready", ready, 1);
    check("rst_done", done, 0);
    check("rst_cens", {SR0_CEN, SR1_CEN, FB_CEN, FB_WEN}, 4'hF);
    check("rst_addrs", {SR0_A, SR1_A, FB_A, FB_D}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int v = 0; v < 6; v++) begin
      for (int i = 0; i < int'(vt[v].n); i++) begin
        if (i == int'(vt[v].n) - 1 && vt[v].n > 1) begin
          sx[i] = vt[v].x1; sy[i] = vt[v].y1; st[i] = vt[v].t1;
        end else begin
          sx[i] = vt[v].x0; sy[i] = vt[v].y0; st[i] = vt[v].t0;
        end
      end
      run_frame(int'(vt[v].n), vt[v].mode, vt[v].bg, 1'b0, 1'b0);
      check($sformatf("vec%0d_probe0", v), fb_mem[vt[v].pa0], vt[v].pe0);
      check($sformatf("vec%0d_probe1", v), fb_mem[vt[v].pa1], vt[v].pe1);
    end

    // Sprite coincident with start is dropped.
    sx[0] = 6'd5; sy[0] = 6'd7; st[0] = 2'd1;
    run_frame(1, 2'd0, 12'h135, 1'b1, 1'b0);
    check("coincide_probe", fb_mem[12'(20 * 64 + 21)], 12'h135);

    // Sprites offered while busy are ignored; list is empty afterwards.
    sx[0] = 6'd30; sy[0] = 6'd2; st[0] = 2'd3;
    run_frame(1, 2'd2, 12'h864, 1'b0, 1'b1);
    run_frame(0, 2'd3, 12'h9AC, 1'b0, 1'b0);

    // Asynchronous reset during DRAW.
    sx[0] = 6'd8; sy[0] = 6'd8; st[0] = 2'd0;
    game_mode = 2'd0; bg_color = 12'h111;
    load_and_start(1, 1'b0);
    found = 0;
    for (int c = 0; c < 6000 && found == 0; c++) begin
      @(negedge clk);
      if (!SR0_CEN) found = 1;
    end
    check("draw_reached", found, 1);
    repeat (20) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midreset_ready", ready, 1);
    check("midreset_done", done, 0);
    check("midreset_cens", {SR0_CEN, SR1_CEN, FB_CEN, FB_WEN}, 4'hF);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_frame(0, 2'd0, 12'h2E2, 1'b0, 1'b0);

    // Randomized ROM contents and sprite lists.
    for (int a = 0; a < 512; a++) begin
      rom0[a] = {($urandom_range(0, 3) == 0), 12'($urandom)};
      rom1[a] = {($urandom_range(0, 3) == 0), 12'($urandom)};
    end
    for (int f = 0; f < 3; f++) begin
      int n;
      n = $urandom_range(1, 6);
      for (int i = 0; i < n; i++) begin
        sx[i] = 6'($urandom); sy[i] = 6'($urandom); st[i] = 2'($urandom);
        if ($urandom_range(0, 2) == 0) sx[i] = 6'($urandom_range(50, 63));
      end
      run_frame(n, 2'($urandom), 12'($urandom), 1'b0, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sgde_engine.md
SGDE_ENGINE -- requirements
Module: sgde_engine

Interface
REQ-001 SHALL have parameter MAX_SPRITES, default 20, maximum number of sprites stored per frame.
REQ-002 SHALL use one clock and an asynchronous, active-low reset; ports: clk input 1 (rising-edge clock); reset input 1 (asynchronous, active-low).
REQ-003 SHALL have the following sprite-load and control ports:
- sprite input 1: sprite-descriptor valid.
- start input 1: begin rendering.
- X input 6 / Y input 6: sprite top-left column / row.
- type input 2: sprite index.
- ready output 1: idle, accepting sprites.
- done output 1: one-cycle frame-complete pulse.
REQ-004 SHALL have the following sprite ROM ports:
- SR0_CEN output 1 / SR0_A output 9 / SR0_Q input 13: sprite ROM 0, holds types 0-1.
- SR1_CEN output 1 / SR1_A output 9 / SR1_Q input 13: sprite ROM 1, holds types 2-3.
REQ-005 SHALL have the following frame-buffer ports:
- FB_CEN output 1 (active-low enable).
- FB_WEN output 1 (active-low write).
- FB_A output 12 / FB_D output 12 / FB_Q input 12.
REQ-006 SHALL have the following configuration ports, both static during a frame:
- bg_color input 12: background RGB444.
- game_mode input 2: draw mode.

Function
REQ-007 SHALL treat SR and FB as synchronous single-port memories: CEN low = access; Q valid one cycle after the address edge; FB writes when CEN=0 and WEN=0.
REQ-008 SHALL map the frame as 64x64 pixels, FB_A = {row[5:0], col[5:0]}.
REQ-009 SHALL define sprites as 16x16 pixels, one SR word per pixel; ROM select = type[1]; SR_A = {type[0], srow[3:0], scol[3:0]}; word = {transparent bit [12], RGB444 [11:0]}.
REQ-010 SHALL use states IDLE, LOAD, CLEAR, DRAW, DONE.
REQ-011 SHALL hold ready=1 in IDLE and LOAD, and ready=0 otherwise.
REQ-012 SHALL capture {X,Y,type} on every rising edge where sprite=1 and ready=1, appending it to the list; sprites beyond MAX_SPRITES are dropped.
REQ-013 SHALL ignore sprite while ready=0.
REQ-014 SHALL, on start=1 with ready=1, enter CLEAR; start has priority, so a coincident sprite is dropped.
REQ-015 SHALL, in CLEAR, write bg_color to all 4096 addresses 0..4095, one per cycle.
REQ-016 SHALL, in DRAW, render sprites in load order; a later sprite overwrites an earlier one.
REQ-017 SHALL, in DRAW, pipeline each sprite at one ROM read per cycle (raster order srow, scol) and perform the FB write one cycle after the read.
REQ-018 SHALL, for game_mode 0, 2 and 3, skip pixels with bit12=1 (transparent).
REQ-019 SHALL, for game_mode 1, write every pixel opaquely, ignoring bit12.
REQ-020 SHALL clip: pixels with X+scol>63 or Y+srow>63 are not written, and no wrap-around occurs.
REQ-021 SHALL, with zero sprites loaded, perform CLEAR only and then go to DONE.
REQ-022 SHALL pulse done=1 for exactly one cycle after the last FB write, then return to IDLE with the list emptied.
REQ-023 SHALL hold FB_CEN=1 and FB_WEN=1 in IDLE and DONE so that external FB access is possible.
REQ-024 SHALL hold CEN=1 on the unused SR.
REQ-025 SHALL meet the latency bound start -> done <= 4096 + N*(256+2) + 4 cycles.

Reset
REQ-026 SHALL, on reset low, immediately (asynchronously) force:
- state = IDLE, ready = 1, done = 0.
- all CEN and WEN = 1.
- all addresses and FB_D = 0.
- sprite count = 0.
REQ-027 SHALL, if reset occurs mid-frame, abort the frame and leave the partial FB contents undefined.

Structure
REQ-028 SHALL place FB_DIM=64, SPR_DIM=16, MAX_SPRITES, the state enum and a sprite-descriptor struct {x,y,type} in package sgde_pkg.
REQ-029 SHALL use one sub-module, sgde_sprite_list (descriptor register file with write pointer, count and read index); the FSM and address generation remain in sgde_engine.

Verification
REQ-030 SHALL cover: 0 sprites, start, bg_color=12'hB97 -> all 4096 FB words = 12'hB97 and one done pulse.
REQ-031 SHALL cover: one sprite at X=0, Y=0, type=0, mode 0 -> FB[{r,c}] = SR0[{0,r,c}][11:0] for non-transparent pixels (r,c<16); transparent pixels and all other pixels = bg_color.
REQ-032 SHALL cover: type=3 at X=60, Y=60 -> SR1 addressed with A[8]=1; only the 4x4 pixels at col/row 60..63 are written; no write at wrapped addresses.
REQ-033 SHALL cover: two overlapping sprites (types 1 then 2, both at X=10, Y=10) -> overlap region shows type-2 opaque pixels; type-1 is visible only where type-2 is transparent.
REQ-034 SHALL cover: 21 sprites loaded -> only the first 20 are drawn.
REQ-035 SHALL cover: mode 1 with a transparent pixel -> that pixel's color is written.
REQ-036 SHALL cover: reset asserted mid-DRAW -> ready=1, done=0 and all CEN=1 immediately.
